// File: rtl/wb_downsizer_pkg.sv
// Shared Wishbone constants, FSM state type and lane-index sizing helper
// for the wide-to-narrow Wishbone downsizer.
package wb_downsizer_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_ACCESS,
        DS_RESP
    } ds_state_e;

    // Width of a lane index; never zero so ports stay legal.
    function automatic int lane_bits(input int scale);
        return (scale > 1) ? $clog2(scale) : 1;
    endfunction

endpackage

// File: rtl/wb_downsizer_lane_pick.sv
// Lowest-set-bit priority encoder over the pending lane mask.
// Lane 0 (lowest address) wins.
module wb_downsizer_lane_pick
    import wb_downsizer_pkg::*;
#(
    parameter int SCALE = 2,
    parameter int LW    = lane_bits(SCALE)
) (
    input  logic [SCALE-1:0] mask,
    output logic [LW-1:0]    lane,
    output logic             any
);

    always_comb begin
        lane = '0;
        any  = 1'b0;
        for (int k = SCALE - 1; k >= 0; k--) begin
            if (mask[k]) begin
                lane = LW'(k);
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_downsizer.sv
// Wide Wishbone slave to narrow classic Wishbone master width converter.
// One narrow access per selected lane, one wide response per wide access.
module wb_downsizer
    import wb_downsizer_pkg::*;
#(
    parameter int DW_OUT = 32,
    parameter int SCALE  = 2,
    parameter int AW     = 32
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_ni,
    input  logic [AW-1:0]              wbs_adr_i,
    input  logic [DW_OUT*SCALE-1:0]    wbs_dat_i,
    input  logic [DW_OUT*SCALE/8-1:0]  wbs_sel_i,
    input  logic                       wbs_we_i,
    input  logic                       wbs_cyc_i,
    input  logic                       wbs_stb_i,
    input  logic [2:0]                 wbs_cti_i,
    input  logic [1:0]                 wbs_bte_i,
    output logic [DW_OUT*SCALE-1:0]    wbs_dat_o,
    output logic                       wbs_ack_o,
    output logic                       wbs_err_o,
    output logic                       wbs_rty_o,
    output logic [AW-1:0]              wbm_adr_o,
    output logic [DW_OUT-1:0]          wbm_dat_o,
    output logic [DW_OUT/8-1:0]        wbm_sel_o,
    output logic                       wbm_we_o,
    output logic                       wbm_cyc_o,
    output logic                       wbm_stb_o,
    output logic [2:0]                 wbm_cti_o,
    output logic [1:0]                 wbm_bte_o,
    input  logic [DW_OUT-1:0]          wbm_dat_i,
    input  logic                       wbm_ack_i,
    input  logic                       wbm_err_i,
    input  logic                       wbm_rty_i
);

    localparam int DW   = DW_OUT * SCALE;
    localparam int SELN = DW_OUT / 8;
    localparam int SW   = DW / 8;
    localparam int LW   = lane_bits(SCALE);
    localparam int OFS  = $clog2(SELN);
    localparam int LOWN = $clog2(SW);
    localparam logic [AW-1:0] HI_MASK = {AW{1'b1}} << LOWN;

    ds_state_e        state_q;
    logic [AW-1:0]    adr_q;
    logic [DW-1:0]    dat_q;
    logic [SW-1:0]    sel_q;
    logic             we_q;
    logic [SCALE-1:0] mask_q;
    logic [LW-1:0]    lane_q;

    logic [SCALE-1:0] req_mask;
    logic [SCALE-1:0] lane_oh;
    logic [SCALE-1:0] pick_in;
    logic [LW-1:0]    pick_lane;
    logic             pick_any;
    logic [AW-1:0]    src_adr;
    logic [DW-1:0]    src_dat;
    logic [SW-1:0]    src_sel;
    logic [AW-1:0]    nxt_adr;
    logic [DW_OUT-1:0] nxt_dat;
    logic [SELN-1:0]  nxt_sel;
    logic             unused_ok;

    assign unused_ok = ^{wbs_cti_i, wbs_bte_i};
    assign wbm_cti_o = CTI_CLASSIC;
    assign wbm_bte_o = BTE_LINEAR;

    always_comb begin
        req_mask = '0;
        for (int k = 0; k < SCALE; k++) begin
            req_mask[k] = |wbs_sel_i[k*SELN +: SELN];
        end
    end

    assign lane_oh = {{(SCALE-1){1'b0}}, 1'b1} << lane_q;

    // In IDLE the picker looks at the incoming request, otherwise at
    // what remains once the current lane is retired.
    always_comb begin
        if (state_q == DS_IDLE) begin
            pick_in = req_mask;
            src_adr = wbs_adr_i;
            src_dat = wbs_dat_i;
            src_sel = wbs_sel_i;
        end else begin
            pick_in = mask_q & ~lane_oh;
            src_adr = adr_q;
            src_dat = dat_q;
            src_sel = sel_q;
        end
    end

    wb_downsizer_lane_pick #(
        .SCALE (SCALE),
        .LW    (LW)
    ) u_pick (
        .mask (pick_in),
        .lane (pick_lane),
        .any  (pick_any)
    );

    assign nxt_adr = (src_adr & HI_MASK) | (AW'(pick_lane) << OFS);
    assign nxt_dat = src_dat[pick_lane*DW_OUT +: DW_OUT];
    assign nxt_sel = src_sel[pick_lane*SELN +: SELN];

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q   <= DS_IDLE;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            mask_q    <= '0;
            lane_q    <= '0;
            wbs_dat_o <= '0;
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            wbs_rty_o <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
            wbm_we_o  <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
        end else begin
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            wbs_rty_o <= 1'b0;
            unique case (state_q)
                DS_IDLE: begin
                    if (wbs_cyc_i && wbs_stb_i) begin
                        adr_q     <= wbs_adr_i;
                        dat_q     <= wbs_dat_i;
                        sel_q     <= wbs_sel_i;
                        we_q      <= wbs_we_i;
                        mask_q    <= req_mask;
                        lane_q    <= pick_lane;
                        wbs_dat_o <= '0;
                        if (pick_any) begin
                            state_q   <= DS_ACCESS;
                            wbm_cyc_o <= 1'b1;
                            wbm_stb_o <= 1'b1;
                            wbm_we_o  <= wbs_we_i;
                            wbm_adr_o <= nxt_adr;
                            wbm_dat_o <= nxt_dat;
                            wbm_sel_o <= nxt_sel;
                        end else begin
                            state_q   <= DS_RESP;
                            wbs_ack_o <= 1'b1;
                        end
                    end
                end
                DS_ACCESS: begin
                    if (!wbs_cyc_i) begin
                        state_q   <= DS_IDLE;
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                    end else if (wbm_err_i) begin
                        state_q   <= DS_RESP;
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbs_err_o <= 1'b1;
                    end else if (wbm_rty_i) begin
                        state_q   <= DS_RESP;
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbs_rty_o <= 1'b1;
                    end else if (wbm_ack_i) begin
                        if (!we_q) begin
                            wbs_dat_o[lane_q*DW_OUT +: DW_OUT] <= wbm_dat_i;
                        end
                        mask_q <= pick_in;
                        lane_q <= pick_lane;
                        if (pick_any) begin
                            wbm_adr_o <= nxt_adr;
                            wbm_dat_o <= nxt_dat;
                            wbm_sel_o <= nxt_sel;
                        end else begin
                            state_q   <= DS_RESP;
                            wbm_cyc_o <= 1'b0;
                            wbm_stb_o <= 1'b0;
                            wbs_ack_o <= 1'b1;
                        end
                    end
                end
                DS_RESP: begin
                    state_q <= DS_IDLE;
                end
                default: begin
                    state_q <= DS_IDLE;
                end
            endcase
        end
    end

endmodule
